// File: rtl/idft8_stream_pkg.sv
// idft8_stream_pkg: shared types, twiddle tables and sample-format helpers for the 8-point IDFT
package idft8_stream_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_UNLOAD
    } state_t;

    // Packed sample layout: {re[7:4], im[3:0]}, both signed 4-bit
    localparam int RE_MSB = 7;
    localparam int RE_LSB = 4;
    localparam int IM_MSB = 3;
    localparam int IM_LSB = 0;

    // Conjugate twiddles W8^-k in Q4, k = 0..3
    localparam int TW_W = 6;
    localparam logic signed [TW_W-1:0] TW_RE [4] = '{6'sd16, 6'sd11, 6'sd0, -6'sd11};
    localparam logic signed [TW_W-1:0] TW_IM [4] = '{6'sd0, 6'sd11, 6'sd16, 6'sd11};

    function automatic logic [2:0] rev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/idft8_butterfly.sv
// idft8_butterfly: combinational radix-2 butterfly, y0 = a + b*w, y1 = a - b*w
//   a_re/a_im, b_re/b_im : CW-bit signed operands
//   w_re/w_im            : Q4 twiddle
//   y0_*/y1_*            : CW-bit results (wrap at CW bits, no scaling)
module idft8_butterfly
    import idft8_stream_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic signed [CW-1:0]   a_re,
    input  logic signed [CW-1:0]   a_im,
    input  logic signed [CW-1:0]   b_re,
    input  logic signed [CW-1:0]   b_im,
    input  logic signed [TW_W-1:0] w_re,
    input  logic signed [TW_W-1:0] w_im,
    output logic signed [CW-1:0]   y0_re,
    output logic signed [CW-1:0]   y0_im,
    output logic signed [CW-1:0]   y1_re,
    output logic signed [CW-1:0]   y1_im
);

    localparam int PW = CW + TW_W + 1;
    localparam logic signed [PW-1:0] RND = PW'(8);

    logic signed [PW-1:0] br, bi, wr, wi, p_re, p_im;
    logic signed [CW-1:0] t_re, t_im;

    always_comb begin
        br    = PW'(b_re);
        bi    = PW'(b_im);
        wr    = PW'(w_re);
        wi    = PW'(w_im);
        // Q4 product with round-half-up before dropping the fraction
        p_re  = br * wr - bi * wi + RND;
        p_im  = br * wi + bi * wr + RND;
        t_re  = CW'(p_re >>> 4);
        t_im  = CW'(p_im >>> 4);
        y0_re = a_re + t_re;
        y0_im = a_im + t_im;
        y1_re = a_re - t_re;
        y1_im = a_im - t_im;
    end

endmodule

// File: rtl/idft8_stream.sv
// idft8_stream: streaming 8-point inverse DFT (load 8 samples, 12 butterflies, unload 8 samples)
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data/in_valid/in_ready    : frequency-domain input stream {re[7:4], im[3:0]}
//   out_data/out_valid/out_ready : time-domain output stream, same packing
//   busy                : high while computing or unloading
module idft8_stream
    import idft8_stream_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam logic signed [CW:0] HALF = (CW+1)'(4);
    localparam logic signed [CW:0] MAXV = (CW+1)'(7);
    localparam logic signed [CW:0] MINV = -(CW+1)'(8);

    state_t state_q, state_d;
    logic [2:0] in_cnt_q, in_cnt_d;
    logic [3:0] bf_q, bf_d;
    logic [2:0] out_cnt_q, out_cnt_d;
    logic signed [CW-1:0] re_q [8];
    logic signed [CW-1:0] re_d [8];
    logic signed [CW-1:0] im_q [8];
    logic signed [CW-1:0] im_d [8];

    logic [1:0] stage, j, tw_idx;
    logic [2:0] a_idx, b_idx;
    logic signed [CW-1:0] y0_re, y0_im, y1_re, y1_im;

    // Final 1/8 scaling with round-half-up, saturated to signed 4-bit
    function automatic logic [3:0] to_q(input logic signed [CW-1:0] v);
        logic signed [CW:0] r;
        r = ((CW+1)'(v) + HALF) >>> 3;
        return r > MAXV ? 4'h7 : r < MINV ? 4'h8 : r[3:0];
    endfunction

    // Butterfly bf_q = {stage, j}: in-place DIT addressing on bit-reversed input
    always_comb begin
        stage  = bf_q[3:2];
        j      = bf_q[1:0];
        a_idx  = stage == 2'd0 ? {j, 1'b0} : stage == 2'd1 ? {j[1], 1'b0, j[0]} : {1'b0, j};
        b_idx  = a_idx | (3'd1 << stage);
        tw_idx = stage == 2'd0 ? 2'd0 : stage == 2'd1 ? {j[0], 1'b0} : j;
    end

    idft8_butterfly #(.CW(CW)) u_bf (
        .a_re  (re_q[a_idx]),
        .a_im  (im_q[a_idx]),
        .b_re  (re_q[b_idx]),
        .b_im  (im_q[b_idx]),
        .w_re  (TW_RE[tw_idx]),
        .w_im  (TW_IM[tw_idx]),
        .y0_re (y0_re),
        .y0_im (y0_im),
        .y1_re (y1_re),
        .y1_im (y1_im)
    );

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        bf_d      = bf_q;
        out_cnt_d = out_cnt_q;
        re_d      = re_q;
        im_d      = im_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    re_d[rev3(in_cnt_q)] = CW'($signed(in_data[RE_MSB:RE_LSB]));
                    im_d[rev3(in_cnt_q)] = CW'($signed(in_data[IM_MSB:IM_LSB]));
                    in_cnt_d = in_cnt_q + 3'd1;
                    state_d  = in_cnt_q == 3'd7 ? ST_COMPUTE : ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                re_d[a_idx] = y0_re;
                im_d[a_idx] = y0_im;
                re_d[b_idx] = y1_re;
                im_d[b_idx] = y1_im;
                bf_d    = bf_q == 4'd11 ? 4'd0 : bf_q + 4'd1;
                state_d = bf_q == 4'd11 ? ST_UNLOAD : ST_COMPUTE;
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    out_cnt_d = out_cnt_q + 3'd1;
                    state_d   = out_cnt_q == 3'd7 ? ST_LOAD : ST_UNLOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            in_cnt_q  <= '0;
            bf_q      <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            bf_q      <= bf_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Sample memory needs no reset: a frame is always fully loaded before use
    always_ff @(posedge clk) begin
        re_q <= re_d;
        im_q <= im_d;
    end

    always_comb begin
        in_ready  = state_q == ST_LOAD;
        out_valid = state_q == ST_UNLOAD;
        busy      = state_q != ST_LOAD;
        out_data  = out_valid ? {to_q(re_q[out_cnt_q]), to_q(im_q[out_cnt_q])} : 8'h00;
    end

endmodule
